// File: rtl/clint_wb_master.sv
// clint_wb_master: Wishbone classic initiator that moves one 64-bit CLINT timer
// register (mtime / mtimecmp) as 32-bit beats selected by wb_adr[0].
// Optional feature macro: CLINT_WB_MASTER_CONSISTENT_READ_EN
//   defined   -> reads run HI, LO, HI2 and retry when the high word moved.
//   undefined -> reads run LO, HI with no compare or retry logic.
// All outputs are registered; their next values are derived from next state.
module clint_wb_master #(
  parameter int unsigned PADDR_SIZE     = 30,
  parameter int unsigned PDATA_SIZE     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [PADDR_SIZE-1:0] cmd_adr,
  input  logic [63:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [63:0]           rsp_rdata,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [PADDR_SIZE-1:0] wb_adr,
  output logic [PDATA_SIZE-1:0] wb_dat_o,
  input  logic [PDATA_SIZE-1:0] wb_dat_i,
  input  logic                  wb_ack
);

  typedef enum logic [1:0] {StIdle, StBeat, StGap, StResp} state_e;
  typedef enum logic [1:0] {BeatLo, BeatHi, BeatHi2} beat_e;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  beat_e                 beat_q, beat_d;
  logic                  we_q, we_d;
  logic [PADDR_SIZE-2:0] adr_q, adr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           hi_q, hi_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [63:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  wb_stb_q, wb_stb_d;
  logic                  wb_we_q, wb_we_d;
  logic [PADDR_SIZE-1:0] wb_adr_q, wb_adr_d;
  logic [PDATA_SIZE-1:0] wb_dat_o_q, wb_dat_o_d;

`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  // The register pair is always addressed as an aligned pair.
  logic unused_adr_lsb;
  assign unused_adr_lsb = cmd_adr[0];

  // Next-state: command latch, beat sequencing, timeout and response data.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cnt_d       = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
    retry_d     = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr[PADDR_SIZE-1:1];
          wdata_d = cmd_wdata;
          lo_d    = '0;
          hi_d    = '0;
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
          retry_d = '0;
          beat_d  = cmd_we ? BeatLo : BeatHi;
`else
          beat_d  = BeatLo;
`endif
          state_d = StBeat;
        end
      end

      StBeat: begin
        if (wb_ack) begin
          state_d = StGap;
          unique case (beat_q)
            BeatLo: begin
              lo_d = wb_dat_i[31:0];
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
              beat_d = we_q ? BeatHi : BeatHi2;
`else
              beat_d = BeatHi;
`endif
            end
            BeatHi: begin
              hi_d = wb_dat_i[31:0];
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
              if (we_q) begin
                state_d = StResp;
              end else begin
                beat_d = BeatLo;
              end
`else
              state_d = StResp;
`endif
            end
            default: begin
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
              // HI2: a changed high word means LO may belong to either epoch.
              if (wb_dat_i[31:0] == hi_q) begin
                state_d = StResp;
              end else if (retry_q < RetryW'(MAX_RETRY)) begin
                hi_d    = wb_dat_i[31:0];
                retry_d = retry_q + RetryW'(1);
                beat_d  = BeatLo;
              end else begin
                state_d   = StResp;
                rsp_err_d = 1'b1;
              end
`else
              state_d   = StResp;
              rsp_err_d = 1'b1;
`endif
            end
          endcase
          if (state_d == StResp && !rsp_err_d && !we_q) begin
            rsp_rdata_d = {hi_d, lo_d};
          end
        end else if (cnt_q + CntW'(1) == CntW'(TIMEOUT_CYCLES)) begin
          state_d   = StResp;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StGap:   state_d = StBeat;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Registered outputs follow the state being entered.
    cmd_ready_d = (state_d == StIdle);
    wb_cyc_d    = (state_d == StBeat) || (state_d == StGap);
    wb_stb_d    = (state_d == StBeat);
    wb_we_d     = wb_stb_d && we_d;
    wb_adr_d    = '0;
    wb_dat_o_d  = '0;
    if (wb_stb_d) begin
      wb_adr_d = {adr_d, beat_d != BeatLo};
      if (we_d) begin
        wb_dat_o_d = (beat_d == BeatLo) ? wdata_d[31:0] : wdata_d[63:32];
      end
    end
    rsp_valid_d = (state_d == StResp);
  end

  // State and registered outputs; async reset drops the bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      beat_q      <= BeatLo;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_o_q  <= '0;
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_o_q  <= wb_dat_o_d;
`ifdef CLINT_WB_MASTER_CONSISTENT_READ_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_adr    = wb_adr_q;
  assign wb_dat_o  = wb_dat_o_q;

endmodule
